clk_en_gen: RTL
===============

CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
REQ-001 Parameter N_CH, default 4, number of clock-enable channels (1..16).
REQ-002 Parameter CNT_W, default 16, divider counter width per channel.
REQ-003 Parameter RST_HOLD, default 16, cycles that all resets are held after lock is seen (1..2^16-1).
REQ-004 clk_32d768M  in  1  sole clock; every register is on its rising edge.
REQ-005 rst_32d768M  in  1  reset, synchronous, active-high.
REQ-006 locked_in  in  1  upstream clock-wizard lock, asynchronous to clk_32d768M.
REQ-007 div_cfg  in  N_CH*CNT_W  per-channel divide ratio; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-008 cfg_load  in  1  one-cycle strobe that captures div_cfg into the shadow registers.
REQ-009 ce_out  out  N_CH  per-channel single-cycle clock-enable pulse.
REQ-010 rst_ch  out  N_CH  per-channel synchronous reset, active-high.
REQ-011 rst_n_ch  out  N_CH  bitwise inverse of rst_ch, registered.
REQ-012 ready  out  1  high when all channels are released and the FSM is in RUN.

Function
REQ-013 locked_in passes through a 2-flop synchroniser to give locked_s, with 2-cycle latency.
REQ-014 FSM states: IDLE, HOLD, RELEASE, RUN.
REQ-015 FSM transitions: IDLE->HOLD when locked_s=1; HOLD->RELEASE after RST_HOLD cycles in HOLD; RELEASE->RUN after N_CH cycles.
REQ-016 In RELEASE, rst_ch[k] deasserts k cycles after rst_ch[0], staggered with ch0 first; ready rises in the same cycle as rst_ch[N_CH-1] falls.
REQ-017 If locked_in first samples high at edge L, rst_ch[0] is first low in cycle L+RST_HOLD+3 and rst_ch[k] in cycle L+RST_HOLD+3+k.
REQ-018 Loss of lock: locked_s=0 in any state forces IDLE on the next edge.
  - rst_ch goes all-ones and ready=0 on that same edge.
  - ce_out goes to 0 and counters reload.
REQ-019 Channel counter while rst_ch[i]=1: holds div_act[i]-1, and ce_out[i]=0.
REQ-020 Channel counter while rst_ch[i]=0: decrements each cycle; ce_out[i]=1 in exactly the cycles where the counter is 0, and the counter then reloads div_act[i]-1.
REQ-021 A ratio of 0 or 1 is treated as 1, so ce_out[i] is high every cycle the channel is released.
REQ-022 cfg_load captures all of div_cfg into the shadow registers.
  - Shadow[i] is copied to div_act[i] only on a cycle where counter i reloads (terminal count or reset hold).
  - No ce pulse is ever shortened or doubled by a ratio change.
REQ-023 cfg_load coinciding with a terminal count: the new shadow value takes effect at the next terminal count, not the current one.
REQ-024 Back-to-back cfg_load strobes: the last one before the terminal count wins.
REQ-025 Counter arithmetic is unsigned CNT_W bits and never underflows below 0.

Reset
REQ-026 While rst_32d768M=1 on an edge, the block takes these values:
  - FSM=IDLE, synchroniser=0, hold counter=0.
  - rst_ch all-ones, rst_n_ch all-zeros, ce_out=0, ready=0.
  - Shadow and div_act both load div_cfg.
REQ-027 rst_32d768M asserted mid-RUN takes effect on the next edge regardless of locked_in.
  - After release, the block repeats the full IDLE->HOLD->RELEASE sequence.

Structure
REQ-028 Package clk_en_pkg holds:
  - the FSM state enum;
  - the default constants N_CH_DEF, CNT_W_DEF, RST_HOLD_DEF;
  - a function clamping ratio 0 to 1.
REQ-029 One sub-module, clk_en_div, is instantiated N_CH times in a generate loop.
  - Each instance implements one channel counter, the shadow/active registers and the ce pulse.
  - The top level holds the synchroniser, the FSM, the hold counter and the release stagger.

Verification
REQ-030 Lock-up sequence (N_CH=4, RST_HOLD=16): locked_in rises at edge 10 -> rst_ch[0] low from cycle 29, rst_ch[3] low from cycle 32, ready high from cycle 32.
REQ-031 Division (div_cfg ch0=1, ch1=4, ch2=0, ch3=1000):
  - ch0 and ch2 pulse every cycle;
  - ch1 pulses on the 4th, 8th, ... released cycle;
  - ch3 pulses every 1000 cycles.
REQ-032 Glitch-free change: ch1 running at 4, cfg_load with ch1=7 two cycles before a terminal count -> one more period of 4, then periods of 7, with no extra pulse.
REQ-033 Lock loss: locked_in drops in RUN -> within 3 edges rst_ch=4'hF, ready=0, ce_out=0; relock repeats the REQ-030 timing.
REQ-034 Sync reset mid-RUN: rst_32d768M pulsed for 1 cycle with locked_in held high -> all outputs at reset values on the next edge, then re-release after RST_HOLD+3 cycles.

Source files
------------

// File: rtl/clk_en_pkg.sv
// Shared definitions for the clock-enable generator: sequencer states,
// default sizing constants and the divide-ratio clamp.
package clk_en_pkg;

  localparam int N_CH_DEF     = 4;
  localparam int CNT_W_DEF    = 16;
  localparam int RST_HOLD_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } clk_en_state_e;

  // A ratio of 0 has no meaning as a divider, so it runs as divide-by-1.
  function automatic logic [31:0] clamp_ratio(input logic [31:0] ratio);
    return (ratio == 32'd0) ? 32'd1 : ratio;
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// One clock-enable channel: shadow/active ratio registers and a down-counter
// that emits a single-cycle enable at terminal count.
module clk_en_div
  import clk_en_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_hold,
  input  logic [CNT_W-1:0] i_cfg,
  input  logic             i_cfg_load,
  output logic             o_ce
);

  logic [CNT_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_act;
  logic [CNT_W-1:0] r_cnt;

  logic [CNT_W-1:0] w_act_next;
  logic [CNT_W-1:0] w_reload_cnt;
  logic [CNT_W-1:0] w_cfg_cnt;
  logic             w_tc;
  logic             w_reload;

  // The active ratio only changes on a reload, so a running period is never
  // cut short or stretched by a new configuration.
  assign w_tc         = ~i_hold & (r_cnt == '0);
  assign w_reload     = i_hold | w_tc;
  assign w_act_next   = w_reload ? r_shadow : r_act;
  assign w_reload_cnt = CNT_W'(clamp_ratio(32'(w_act_next)) - 32'd1);
  assign w_cfg_cnt    = CNT_W'(clamp_ratio(32'(i_cfg)) - 32'd1);
  assign o_ce         = w_tc;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_shadow <= i_cfg;
      r_act    <= i_cfg;
      r_cnt    <= w_cfg_cnt;
    end else begin
      if (i_cfg_load) begin
        r_shadow <= i_cfg;
      end
      r_act <= w_act_next;
      r_cnt <= w_reload ? w_reload_cnt : (r_cnt - CNT_W'(1));
    end
  end

endmodule

// File: rtl/clk_en_gen.sv
// Clock-enable generator: synchronises the clock-wizard lock, sequences the
// hold/staggered release of per-channel resets and drives N_CH dividers.
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int N_CH     = N_CH_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int RST_HOLD = RST_HOLD_DEF
) (
  input  logic                  clk_32d768M,
  input  logic                  rst_32d768M,
  input  logic                  locked_in,
  input  logic [N_CH*CNT_W-1:0] div_cfg,
  input  logic                  cfg_load,
  output logic [N_CH-1:0]       ce_out,
  output logic [N_CH-1:0]       rst_ch,
  output logic [N_CH-1:0]       rst_n_ch,
  output logic                  ready
);

  localparam int REL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              r_sync1;
  logic              r_locked_s;
  clk_en_state_e     r_state;
  logic [15:0]       r_hold_cnt;
  logic [REL_W-1:0]  r_rel_cnt;
  logic [N_CH-1:0]   r_rst_ch;
  logic [N_CH-1:0]   r_rst_n_ch;
  logic              r_ready;
  logic [N_CH-1:0]   w_ce;

  always_ff @(posedge clk_32d768M) begin
    if (rst_32d768M) begin
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_rel_cnt  <= '0;
      r_rst_ch   <= '1;
      r_rst_n_ch <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_sync1    <= locked_in;
      r_locked_s <= r_sync1;
      if (!r_locked_s) begin
        // Losing lock anywhere drops every channel back into reset at once.
        r_state    <= ST_IDLE;
        r_hold_cnt <= '0;
        r_rel_cnt  <= '0;
        r_rst_ch   <= '1;
        r_rst_n_ch <= '0;
        r_ready    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
          end
          ST_HOLD: begin
            if (r_hold_cnt == 16'(RST_HOLD - 1)) begin
              r_state   <= ST_RELEASE;
              r_rel_cnt <= '0;
            end else begin
              r_hold_cnt <= r_hold_cnt + 16'd1;
            end
          end
          ST_RELEASE: begin
            // One channel leaves reset per cycle, channel 0 first.
            for (int k = 0; k < N_CH; k++) begin
              if (r_rel_cnt == REL_W'(k)) begin
                r_rst_ch[k]   <= 1'b0;
                r_rst_n_ch[k] <= 1'b1;
              end
            end
            if (r_rel_cnt == REL_W'(N_CH - 1)) begin
              r_state <= ST_RUN;
              r_ready <= 1'b1;
            end else begin
              r_rel_cnt <= r_rel_cnt + REL_W'(1);
            end
          end
          ST_RUN: begin
            r_state <= ST_RUN;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      clk_en_div #(
        .CNT_W(CNT_W)
      ) u_div (
        .i_clk      (clk_32d768M),
        .i_srst     (rst_32d768M),
        .i_hold     (r_rst_ch[gi]),
        .i_cfg      (div_cfg[gi*CNT_W +: CNT_W]),
        .i_cfg_load (cfg_load),
        .o_ce       (w_ce[gi])
      );
    end
  endgenerate

  assign ce_out   = w_ce;
  assign rst_ch   = r_rst_ch;
  assign rst_n_ch = r_rst_n_ch;
  assign ready    = r_ready;

endmodule
